// File: rtl/ser_pkg.sv
// Shared types and limits for the parallel-in/serial-out bit serializer.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_t;

    localparam int unsigned SER_MAX_WIDTH = 32;

endpackage : ser_pkg

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer feeding the 1101 detector's serial input.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// clock with a qualifying dout_valid strobe.
// Optional macro SER_GAP_EN: inserts one idle (dout=0, dout_valid=0) cycle
// after every word so a pattern can never straddle a word boundary.
module piso_bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Reject out-of-range widths at elaboration.
    if (WIDTH < 1 || WIDTH > SER_MAX_WIDTH) begin : g_bad_width
        $error("piso_bit_serializer: WIDTH out of range");
    end

    ser_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_shifted;
    logic [WIDTH-1:0] shreg_shifted;

    // Ready depends only on state and bits remaining, never on load_valid.
`ifdef SER_GAP_EN
    assign load_ready = (state == S_IDLE);
`else
    assign load_ready = (state == S_IDLE) ||
                        ((state == S_SHIFT) && (cnt == CW'(0)));
`endif

    assign accept = load_valid && load_ready;

    // The shift register holds the bits not yet displayed, aligned so the
    // next bit to show always sits at the outgoing end.
    assign first_bit     = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign next_bit      = MSB_FIRST ? shreg[WIDTH-1]     : shreg[0];
    assign load_shifted  = MSB_FIRST ? (load_data << 1)   : (load_data >> 1);
    assign shreg_shifted = MSB_FIRST ? (shreg << 1)       : (shreg >> 1);

    // FSM, shift register, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= S_SHIFT;
            shreg      <= load_shifted;
            cnt        <= CW'(WIDTH - 1);
            dout       <= first_bit;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                S_SHIFT: begin
                    if (cnt != CW'(0)) begin
                        shreg <= shreg_shifted;
                        cnt   <= cnt - CW'(1);
                        dout  <= next_bit;
                    end else begin
`ifdef SER_GAP_EN
                        state <= S_GAP;
                        busy  <= 1'b1;
`else
                        state <= S_IDLE;
                        busy  <= 1'b0;
`endif
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                    end
                end
`ifdef SER_GAP_EN
                S_GAP: begin
                    state      <= S_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule : piso_bit_serializer

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer (WIDTH=8, both bit orders).
// Reference model: a queue of bits still to be displayed, head = current dout.
module tb_piso_bit_serializer;

`ifdef SER_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_ready, dout, dout_valid, busy;

    logic       lv1 = 1'b0;
    logic [7:0] ld1 = 8'h00;
    logic       lr1, do1, dv1, bz1;

    int checks = 0;
    int failures = 0;

    // model state
    logic mq[$];
    bit   mgap = 1'b0;
    logic exp_dout = 1'b0, exp_dv = 1'b0, exp_busy = 1'b0;
    bit   last_acc = 1'b0;

    always #5 clock = ~clock;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy));

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .load_valid(lv1), .load_data(ld1),
        .load_ready(lr1), .dout(do1), .dout_valid(dv1), .busy(bz1));

    // Serializer may take a word when nothing (or only the last bit) remains.
    function automatic bit m_ready();
        if (GAP) return (mq.size() == 0) && !mgap;
        return mq.size() <= 1;
    endfunction

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        bit acc;
        load_valid = v;
        load_data  = d;
        reset      = r;
        acc = !r && v && m_ready();
        @(posedge clock);
        if (r) begin
            mq.delete();
            mgap = 1'b0;
        end else if (acc) begin
            mq.delete();
            for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
            mgap = 1'b0;
        end else if (mq.size() > 0) begin
            void'(mq.pop_front());
            mgap = GAP && (mq.size() == 0);
        end else begin
            mgap = 1'b0;
        end
        exp_dv   = (mq.size() > 0);
        exp_dout = (mq.size() > 0) ? mq[0] : 1'b0;
        exp_busy = (mq.size() > 0) || mgap;
        last_acc = acc;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'hFF, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        checks++;
        if ({dout, dout_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000", {dout, dout_valid, busy});
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", load_ready);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if ({dout, dout_valid, busy, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_with_valid got=%b want=0001", {dout, dout_valid, busy, load_ready});
        end
    endtask

    task automatic test_single();
        logic [7:0] got = 8'h00;
        drive(1'b1, 8'hD0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if ({dout, dout_valid, busy} !== {exp_dout, exp_dv, exp_busy}) begin
                failures++;
                $display("FAIL single_bit%0d got=%b want=%b", i,
                         {dout, dout_valid, busy}, {exp_dout, exp_dv, exp_busy});
            end
            checks++;
            if (load_ready !== m_ready()) begin
                failures++;
                $display("FAIL single_ready%0d got=%b want=%b", i, load_ready, m_ready());
            end
            if (i < 8) got = {got[6:0], dout};
            drive(1'b0, 8'h00, 1'b0);
        end
        checks++;
        if (got !== 8'hD0) begin
            failures++;
            $display("FAIL single_word got=%h want=d0", got);
        end
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        int acc_n = 0, vcount = 0, first = -1, last = -1;
        logic [15:0] got = 16'h0;
        words[0] = 8'hDD;
        words[1] = 8'hB5;
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (load_ready !== m_ready()) begin
                failures++;
                $display("FAIL b2b_ready c%0d got=%b want=%b", c, load_ready, m_ready());
            end
            drive(acc_n < 2, (acc_n < 2) ? words[acc_n] : 8'h00, 1'b0);
            if (last_acc) acc_n++;
            checks++;
            if ({dout, dout_valid, busy} !== {exp_dout, exp_dv, exp_busy}) begin
                failures++;
                $display("FAIL b2b_out c%0d got=%b want=%b", c,
                         {dout, dout_valid, busy}, {exp_dout, exp_dv, exp_busy});
            end
            if (dout_valid === 1'b1) begin
                got = {got[14:0], dout};
                vcount++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (got !== 16'hDDB5 || vcount != 16) begin
            failures++;
            $display("FAIL b2b_stream got=%h/%0d want=ddb5/16", got, vcount);
        end
        checks++;
        if (last - first + 1 != (GAP ? 17 : 16)) begin
            failures++;
            $display("FAIL b2b_span got=%0d want=%0d", last - first + 1, GAP ? 17 : 16);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'hFF, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if ({dout, dout_valid, busy, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0001", {dout, dout_valid, busy, load_ready});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            checks++;
            if (dout_valid !== 1'b0 || dout !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_tail%0d got=%b%b want=00", i, dout, dout_valid);
            end
        end
    endtask

    task automatic test_ignore();
        logic [7:0] got = 8'h00;
        int n = 0, acc_at = -1;
        drive(1'b1, 8'hAA, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (dout_valid === 1'b1 && n < 8) begin
                got = {got[6:0], dout};
                n++;
            end
            checks++;
            if ({dout, dout_valid, busy, load_ready} !== {exp_dout, exp_dv, exp_busy, m_ready()}) begin
                failures++;
                $display("FAIL ignore c%0d got=%b want=%b", c, {dout, dout_valid, busy, load_ready},
                         {exp_dout, exp_dv, exp_busy, m_ready()});
            end
            drive((c >= 1) && (acc_at < 0), 8'h00, 1'b0);
            if (last_acc) acc_at = c;
        end
        checks++;
        if (got !== 8'hAA) begin
            failures++;
            $display("FAIL ignore_word got=%h want=aa", got);
        end
        checks++;
        if (acc_at != (GAP ? 9 : 7)) begin
            failures++;
            $display("FAIL ignore_accept_cycle got=%0d want=%0d", acc_at, GAP ? 9 : 7);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] want = 8'b11010000;
        lv1 = 1'b1;
        ld1 = 8'h0B;
        @(posedge clock);
        #1;
        lv1 = 1'b0;
        ld1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (do1 !== want[7-i] || dv1 !== 1'b1) begin
                failures++;
                $display("FAIL lsb_bit%0d got=%b%b want=%b1", i, do1, dv1, want[7-i]);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (do1 !== 1'b0 || dv1 !== 1'b0) begin
            failures++;
            $display("FAIL lsb_end got=%b%b want=00", do1, dv1);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic v, r;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            r = ($urandom_range(0, 60) == 0);
            checks++;
            if (load_ready !== m_ready()) begin
                failures++;
                $display("FAIL rand_ready c%0d got=%b want=%b", c, load_ready, m_ready());
            end
            drive(v, d, r);
            checks++;
            if ({dout, dout_valid, busy} !== {exp_dout, exp_dv, exp_busy}) begin
                failures++;
                $display("FAIL rand_out c%0d got=%b want=%b", c,
                         {dout, dout_valid, busy}, {exp_dout, exp_dv, exp_busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_ignore();
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0);
        test_lsb_first();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso_bit_serializer

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
Parallel-in/serial-out stage that sits directly upstream of the 1101 sequence detector and drives its serial `din` input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits the word one bit per clock, with a qualifying valid strobe.
- Lets the detector be fed from word-oriented logic and benches instead of hand-toggled bits.

Parameters:
- WIDTH, 8: bits per word; legal range 1..32.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  producer presents a word on load_data.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  serializer can accept a word this cycle.
- dout  output  1  serial bit; connects to detector din.
- dout_valid  output  1  dout carries a word bit this cycle.
- busy  output  1  a word is in flight (state != S_IDLE).

Behaviour:
- Single clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: dout=0, dout_valid=0, busy=0, state=S_IDLE, shift register=0, bit counter=0. load_ready reads 1 in the first cycle after reset.
- States:
  - S_IDLE: no word held.
  - S_SHIFT: emitting bits.
  - S_GAP: optional feature only.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
  - At that edge the word loads into the shift register.
  - dout takes the first bit, dout_valid goes to 1, and the counter loads WIDTH-1 (bits remaining after the displayed bit).
- Latency: first bit is visible the cycle after the accepting edge. The word occupies exactly WIDTH consecutive dout_valid cycles.
- Shifting: each edge in S_SHIFT with counter>0 presents the next bit (order per MSB_FIRST) and decrements the counter. All outputs are registered.
- load_ready:
  - = 1 in S_IDLE.
  - = 1 in S_SHIFT when counter==0, i.e. the last bit is displayed.
  - = 0 otherwise. It is combinational from state and counter only, never from load_valid.
- Back-to-back: an accept during the last bit streams the next word with no bubble, so dout_valid stays 1.
- End of word with no new accept: next edge goes to S_IDLE, with dout=0 and dout_valid=0. dout is held at 0 whenever dout_valid=0.
- load_valid while load_ready=0 is ignored. The in-flight word is not disturbed; the producer must hold the word.
- WIDTH=1: counter is always 0, so load_ready is 1 every cycle and continuous accepts give continuous dout_valid.
- Reset mid-word: the word is discarded and all outputs return to reset values on the reset edge. No partial bits follow.
- Reset and load_valid together: reset wins and no word is accepted.
- Counter width is $clog2(WIDTH), minimum 1 bit.

Optional Feature:
- Macro SER_GAP_EN.
- Defined:
  - After the last bit, the FSM enters S_GAP for exactly one cycle (dout=0, dout_valid=0), then S_IDLE.
  - load_ready is asserted only in S_IDLE, so consecutive words are separated by at least one 0 gap bit. This guarantees a pattern cannot straddle a word boundary into the non-overlapping detector.
- Undefined: S_GAP is not generated; back-to-back streaming as described above.

Decomposition:
- Package ser_pkg holds:
  - typedef enum logic [1:0] ser_state_t {S_IDLE, S_SHIFT, S_GAP};
  - localparam SER_MAX_WIDTH = 32.
- Single module; no sub-module. The shift register, counter and FSM are too small to justify a split.
- The bench instantiates piso_bit_serializer feeding the existing detector: dout to din, with shared clock and reset.

Test Plan:
- WIDTH=8, MSB_FIRST=1, accept 8'hD0 → dout = 1,1,0,1,0,0,0,0 over 8 cycles, dout_valid=1 throughout; detector pulses once, on the 4th bit.
- Back-to-back 8'hDD then 8'hB5, load_valid held → 16 contiguous dout_valid cycles, sequence 11011101_10110101, load_ready high only on bit 8 and bit 16.
- Reset asserted after 3 bits of 8'hFF → next cycle dout=0, dout_valid=0, busy=0, load_ready=1; no remaining bits emitted.
- load_valid with 8'h00 during bits 2..7 of 8'hAA → ignored; full 10101010 emitted, then 8'h00 accepted on bit 8.
- MSB_FIRST=0, accept 8'h0B → dout = 1,1,0,1,0,0,0,0.
- SER_GAP_EN defined, back-to-back 8'h0D, 8'hD0 → one dout_valid=0 cycle with dout=0 between words; total 17 cycles.
